res_station_bank: RTL and testbench
===================================

RES_STATION_BANK -- requirements
Module: res_station_bank

Interface
REQ-001 Parameter ENTRIES, 4, number of station entries (2..8).
REQ-002 Parameter DATA_W, 16, operand width.
REQ-003 Parameter TAG_W, 3, tag width; tag 0 means "value present".
REQ-004 Parameter OP_W, 4, opcode width.
REQ-005 Parameter BASE_TAG, 1, tag of entry 0; entry i owns tag BASE_TAG+i, never 0.
REQ-006 Clock  in  1  single clock; all state updates on its rising edge.
REQ-007 Reset  in  1  asynchronous, active-low; clears all state immediately.
REQ-008 flush  in  1  synchronous clear of all entries.
REQ-009 iss_valid  in  1  issue request.
REQ-010 iss_ready  out  1  at least one entry free.
REQ-011 iss_op  in  OP_W  opcode to store.
REQ-012 iss_vj, iss_vk  in  DATA_W  operand values, used when the matching Q is 0.
REQ-013 iss_qj, iss_qk  in  TAG_W  producer tags; 0 means operand valid.
REQ-014 iss_tag  out  TAG_W  tag of the entry the issue would take: BASE_TAG + lowest free index.
REQ-015 cdb_valid  in  1  result broadcast valid.
REQ-016 cdb_tag  in  TAG_W  tag of the broadcast result.
REQ-017 cdb_value  in  DATA_W  broadcast value.
REQ-018 ex_valid  out  1  dispatch request to functional unit.
REQ-019 ex_ready  in  1  functional unit accepts.
REQ-020 ex_op, ex_vj, ex_vk, ex_tag  out  OP_W/DATA_W/DATA_W/TAG_W  dispatched entry contents and tag.
REQ-021 count  out  clog2(ENTRIES+1)  number of busy entries.

Function
REQ-022 Each entry SHALL hold Busy, Op, Vj, Vk, Qj, Qk; an entry is ready when Busy and Qj==0 and Qk==0.
REQ-023 Issue SHALL occur when iss_valid && iss_ready: the lowest-index free entry becomes Busy with iss_op/iss_v*/iss_q*.
REQ-024 iss_valid with iss_ready=0 SHALL be ignored with no state change.
REQ-025 On cdb_valid, every busy entry with Qj==cdb_tag SHALL load Vj=cdb_value, Qj=0; likewise for Qk.
REQ-026 Issue bypass: if cdb_valid and iss_qj==cdb_tag (nonzero) in the issue cycle, the entry SHALL store Vj=cdb_value, Qj=0; likewise for k.
REQ-027 A cdb_tag of 0 SHALL be ignored.
REQ-028 ex_valid SHALL be 1 whenever any entry is ready; the selected entry is the lowest-index ready entry.
REQ-029 While ex_valid && !ex_ready, the selected entry SHALL be latched and ex_* held stable until the handshake completes.
REQ-030 On ex_valid && ex_ready the selected entry SHALL be cleared (Busy=0) at that edge; ex_valid may reassert the next cycle for another entry.
REQ-031 Latency: issue with both Q=0 at edge t gives ex_valid=1 in cycle t+1; CDB wakeup of the last operand at edge t gives ex_valid in cycle t+1.
REQ-032 iss_ready and iss_tag SHALL depend only on registered Busy bits; an entry freed by dispatch at edge t is issuable from cycle t+1.
REQ-033 Simultaneous issue and dispatch in one cycle SHALL both take effect; count changes by 0.
REQ-034 Full (count==ENTRIES): iss_ready=0; empty: ex_valid=0, iss_tag=BASE_TAG.
REQ-035 flush SHALL take priority over issue, CDB and dispatch: all Busy=0, selection lock released.
REQ-036 When ex_valid=0, ex_op/ex_vj/ex_vk/ex_tag SHALL be 0.

Reset
REQ-037 Reset low SHALL asynchronously clear all Busy, Op, V, Q, the selection lock and count; ex_valid=0, ex_* =0, iss_ready=1, iss_tag=BASE_TAG.
REQ-038 Reset mid-stall SHALL drop ex_valid without a handshake; outstanding entries are lost.

Verification (ENTRIES=4, BASE_TAG=1, TAG_W=3)
REQ-039 Issue op=2, vj=5, vk=7, qj=qk=0 -> iss_tag=1, next cycle ex_valid=1, ex_vj=5, ex_vk=7, ex_tag=1; ex_ready=1 -> count 1->0.
REQ-040 Issue qj=3, vk=9; later cdb_valid, tag=3, value=0x00AA -> next cycle ex_valid=1, ex_vj=0x00AA, ex_vk=9.
REQ-041 Issue qj=4 while cdb_valid, tag=4, value=0x1234 in the same cycle -> entry ready next cycle, ex_vj=0x1234.
REQ-042 Four issues -> count=4, iss_ready=0, fifth iss_valid ignored; one dispatch -> iss_ready=1, iss_tag = freed entry's tag.
REQ-043 Entry 1 ready, ex_ready=0 for 3 cycles, entry 0 becomes ready meanwhile -> ex_tag stays 2 until handshake, then 1.
REQ-044 Reset asserted asynchronously mid-stall with count=3 -> ex_valid=0, count=0 immediately; flush pulse gives the same result at the next edge.

Source files
------------

// File: rtl/res_station_bank_if.sv
// Issue, CDB and dispatch signal bundle for the reservation station bank.
// The slave modport is the station itself; the master modport drives it.
interface res_station_bank_if #(
    parameter int ENTRIES = 4,
    parameter int DATA_W  = 16,
    parameter int TAG_W   = 3,
    parameter int OP_W    = 4
);
    localparam int CNT_W = $clog2(ENTRIES + 1);

    logic              iss_valid;
    logic              iss_ready;
    logic [OP_W-1:0]   iss_op;
    logic [DATA_W-1:0] iss_vj;
    logic [DATA_W-1:0] iss_vk;
    logic [TAG_W-1:0]  iss_qj;
    logic [TAG_W-1:0]  iss_qk;
    logic [TAG_W-1:0]  iss_tag;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_value;
    logic              ex_valid;
    logic              ex_ready;
    logic [OP_W-1:0]   ex_op;
    logic [DATA_W-1:0] ex_vj;
    logic [DATA_W-1:0] ex_vk;
    logic [TAG_W-1:0]  ex_tag;
    logic [CNT_W-1:0]  count;

    modport master (
        output iss_valid, iss_op, iss_vj, iss_vk, iss_qj, iss_qk,
        output cdb_valid, cdb_tag, cdb_value, ex_ready,
        input  iss_ready, iss_tag, ex_valid, ex_op, ex_vj, ex_vk, ex_tag, count
    );

    modport slave (
        input  iss_valid, iss_op, iss_vj, iss_vk, iss_qj, iss_qk,
        input  cdb_valid, cdb_tag, cdb_value, ex_ready,
        output iss_ready, iss_tag, ex_valid, ex_op, ex_vj, ex_vk, ex_tag, count
    );
endinterface

// File: rtl/res_station_bank.sv
// Tomasulo-style reservation station bank: issue into the lowest free entry,
// wake operands from the CDB, dispatch the lowest ready entry with a stall lock.
module res_station_bank #(
    parameter int ENTRIES  = 4,
    parameter int DATA_W   = 16,
    parameter int TAG_W    = 3,
    parameter int OP_W     = 4,
    parameter int BASE_TAG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    res_station_bank_if.slave bus
);
    localparam int CNT_W = $clog2(ENTRIES + 1);
    localparam int IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0] busy_q;
    logic [OP_W-1:0]    op_q [ENTRIES];
    logic [DATA_W-1:0]  vj_q [ENTRIES];
    logic [DATA_W-1:0]  vk_q [ENTRIES];
    logic [TAG_W-1:0]   qj_q [ENTRIES];
    logic [TAG_W-1:0]   qk_q [ENTRIES];
    logic               lock_q;
    logic [IDX_W-1:0]   sel_q;

    logic [ENTRIES-1:0] rdy_s;
    logic [IDX_W-1:0]   free_idx_s;
    logic [IDX_W-1:0]   rdy_idx_s;
    logic [IDX_W-1:0]   sel_idx_s;
    logic [CNT_W-1:0]   cnt_s;
    logic               cdb_hit_s;
    logic               issue_s;
    logic               dispatch_s;
    logic               ex_valid_s;
    logic               byp_j_s;
    logic               byp_k_s;

    // Lowest free / lowest ready entry search and busy population count
    always_comb begin
        free_idx_s = '0;
        rdy_idx_s  = '0;
        cnt_s      = '0;
        rdy_s      = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            rdy_s[i]   = busy_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
            free_idx_s = busy_q[i] ? free_idx_s : IDX_W'(i);
            rdy_idx_s  = rdy_s[i] ? IDX_W'(i) : rdy_idx_s;
            cnt_s      = cnt_s + CNT_W'(busy_q[i]);
        end
    end

    // A zero CDB tag would otherwise match every entry whose operand is already present
    assign cdb_hit_s  = bus.cdb_valid && (bus.cdb_tag != '0);
    assign issue_s    = bus.iss_valid && !(&busy_q);
    assign ex_valid_s = lock_q || (|rdy_s);
    assign sel_idx_s  = lock_q ? sel_q : rdy_idx_s;
    assign dispatch_s = ex_valid_s && bus.ex_ready;
    assign byp_j_s    = cdb_hit_s && (bus.iss_qj == bus.cdb_tag);
    assign byp_k_s    = cdb_hit_s && (bus.iss_qk == bus.cdb_tag);

    // Output view: all outputs derive only from registered entry state
    always_comb begin
        bus.iss_ready = !(&busy_q);
        bus.iss_tag   = TAG_W'(BASE_TAG) + TAG_W'(free_idx_s);
        bus.count     = cnt_s;
        bus.ex_valid  = ex_valid_s;
        if (ex_valid_s) begin
            bus.ex_op  = op_q[sel_idx_s];
            bus.ex_vj  = vj_q[sel_idx_s];
            bus.ex_vk  = vk_q[sel_idx_s];
            bus.ex_tag = TAG_W'(BASE_TAG) + TAG_W'(sel_idx_s);
        end else begin
            bus.ex_op  = '0;
            bus.ex_vj  = '0;
            bus.ex_vk  = '0;
            bus.ex_tag = '0;
        end
    end

    // Entry storage: flush outranks issue, CDB wakeup and dispatch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                op_q[i] <= '0;
                vj_q[i] <= '0;
                vk_q[i] <= '0;
                qj_q[i] <= '0;
                qk_q[i] <= '0;
            end
        end else if (flush_i) begin
            busy_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                op_q[i] <= '0;
                vj_q[i] <= '0;
                vk_q[i] <= '0;
                qj_q[i] <= '0;
                qk_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (cdb_hit_s && busy_q[i] && (qj_q[i] == bus.cdb_tag)) begin
                    vj_q[i] <= bus.cdb_value;
                    qj_q[i] <= '0;
                end
                if (cdb_hit_s && busy_q[i] && (qk_q[i] == bus.cdb_tag)) begin
                    vk_q[i] <= bus.cdb_value;
                    qk_q[i] <= '0;
                end
                if (dispatch_s && (sel_idx_s == IDX_W'(i))) begin
                    busy_q[i] <= 1'b0;
                end
                // Issue targets a free entry, so it never collides with wakeup or dispatch
                if (issue_s && (free_idx_s == IDX_W'(i))) begin
                    busy_q[i] <= 1'b1;
                    op_q[i]   <= bus.iss_op;
                    vj_q[i]   <= byp_j_s ? bus.cdb_value : bus.iss_vj;
                    qj_q[i]   <= byp_j_s ? '0 : bus.iss_qj;
                    vk_q[i]   <= byp_k_s ? bus.cdb_value : bus.iss_vk;
                    qk_q[i]   <= byp_k_s ? '0 : bus.iss_qk;
                end
            end
        end
    end

    // Selection lock keeps ex_* stable while the functional unit stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= 1'b0;
            sel_q  <= '0;
        end else if (flush_i) begin
            lock_q <= 1'b0;
            sel_q  <= '0;
        end else begin
            lock_q <= ex_valid_s && !bus.ex_ready;
            sel_q  <= sel_idx_s;
        end
    end
endmodule

// File: tb/tb_res_station_bank.sv
// Directed bench for res_station_bank: expected dispatches are queued by the
// stimulus and checked by a monitor on every ex handshake.
module tb_res_station_bank;
    localparam int ENTRIES  = 4;
    localparam int DATA_W   = 16;
    localparam int TAG_W    = 3;
    localparam int OP_W     = 4;
    localparam int BASE_TAG = 1;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    int   checks = 0;
    int   errors = 0;
    logic [38:0] exp_q [$];
    logic [38:0] exp_rec;

    res_station_bank_if #(.ENTRIES(ENTRIES), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W)) bus ();

    res_station_bank #(
        .ENTRIES(ENTRIES), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W), .BASE_TAG(BASE_TAG)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush_i(flush),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input logic [3:0] op, input logic [15:0] vj, input logic [15:0] vk,
                             input logic [2:0] qj, input logic [2:0] qk);
        bus.iss_valid = 1'b1;
        bus.iss_op    = op;
        bus.iss_vj    = vj;
        bus.iss_vk    = vk;
        bus.iss_qj    = qj;
        bus.iss_qk    = qk;
    endtask

    function automatic logic [38:0] rec(input logic [3:0] op, input logic [15:0] vj,
                                        input logic [15:0] vk, input logic [2:0] tag);
        return {op, vj, vk, tag};
    endfunction

    // Scoreboard monitor: every completed dispatch must match the queue head
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.ex_valid === 1'b1 && bus.ex_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("dispatch_unexpected", 64'd1, 64'd0);
            end else begin
                exp_rec = exp_q.pop_front();
                chk("dispatch", 64'({bus.ex_op, bus.ex_vj, bus.ex_vk, bus.ex_tag}), 64'(exp_rec));
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.iss_valid = 1'b0;
        bus.iss_op    = 4'd0;
        bus.iss_vj    = 16'd0;
        bus.iss_vk    = 16'd0;
        bus.iss_qj    = 3'd0;
        bus.iss_qk    = 3'd0;
        bus.cdb_valid = 1'b0;
        bus.cdb_tag   = 3'd0;
        bus.cdb_value = 16'd0;
        bus.ex_ready  = 1'b0;
        #12;
        chk("rst_ex_valid", 64'(bus.ex_valid), 64'd0);
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_iss_ready", 64'(bus.iss_ready), 64'd1);
        chk("rst_iss_tag", 64'(bus.iss_tag), 64'd1);
        chk("rst_ex_bus", 64'({bus.ex_op, bus.ex_vj, bus.ex_vk, bus.ex_tag}), 64'd0);
        rst_n = 1'b1;
        tick();

        // Ready issue, then issue alongside dispatch
        bus.ex_ready = 1'b1;
        set_issue(4'd2, 16'd5, 16'd7, 3'd0, 3'd0);
        chk("t1_iss_tag", 64'(bus.iss_tag), 64'd1);
        exp_q.push_back(rec(4'd2, 16'd5, 16'd7, 3'd1));
        tick();
        set_issue(4'd3, 16'd1, 16'd2, 3'd0, 3'd0);
        chk("t1_count", 64'(bus.count), 64'd1);
        chk("t1_ex_valid", 64'(bus.ex_valid), 64'd1);
        chk("t1_ex_tag", 64'(bus.ex_tag), 64'd1);
        chk("t1_iss_tag2", 64'(bus.iss_tag), 64'd2);
        exp_q.push_back(rec(4'd3, 16'd1, 16'd2, 3'd2));
        tick();
        bus.iss_valid = 1'b0;
        chk("t1_count_same", 64'(bus.count), 64'd1);
        tick();
        chk("t1_count_empty", 64'(bus.count), 64'd0);
        chk("t1_ex_valid_empty", 64'(bus.ex_valid), 64'd0);
        chk("t1_ex_bus_zero", 64'({bus.ex_op, bus.ex_vj, bus.ex_vk, bus.ex_tag}), 64'd0);

        // CDB wakeup of a waiting operand
        set_issue(4'd3, 16'd0, 16'd9, 3'd3, 3'd0);
        tick();
        bus.iss_valid = 1'b0;
        chk("t2_waiting", 64'(bus.ex_valid), 64'd0);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 3'd3;
        bus.cdb_value = 16'h00AA;
        exp_q.push_back(rec(4'd3, 16'h00AA, 16'd9, 3'd1));
        tick();
        bus.cdb_valid = 1'b0;
        chk("t2_ex_valid", 64'(bus.ex_valid), 64'd1);
        chk("t2_ex_vj", 64'(bus.ex_vj), 64'h00AA);
        tick();
        chk("t2_count", 64'(bus.count), 64'd0);

        // Zero CDB tag must not disturb present operands
        bus.ex_ready = 1'b0;
        set_issue(4'd1, 16'h0011, 16'h0022, 3'd0, 3'd0);
        tick();
        bus.iss_valid = 1'b0;
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 3'd0;
        bus.cdb_value = 16'hFFFF;
        tick();
        bus.cdb_valid = 1'b0;
        chk("tag0_ex_vj", 64'(bus.ex_vj), 64'h0011);
        exp_q.push_back(rec(4'd1, 16'h0011, 16'h0022, 3'd1));
        bus.ex_ready = 1'b1;
        tick();
        chk("tag0_count", 64'(bus.count), 64'd0);

        // Issue bypass from a same-cycle broadcast
        set_issue(4'd5, 16'd0, 16'h0055, 3'd4, 3'd0);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 3'd4;
        bus.cdb_value = 16'h1234;
        exp_q.push_back(rec(4'd5, 16'h1234, 16'h0055, 3'd1));
        tick();
        bus.iss_valid = 1'b0;
        bus.cdb_valid = 1'b0;
        chk("t3_ex_valid", 64'(bus.ex_valid), 64'd1);
        chk("t3_ex_vj", 64'(bus.ex_vj), 64'h1234);
        tick();
        chk("t3_count", 64'(bus.count), 64'd0);

        // Fill, ignored fifth issue, then one dispatch frees entry 0
        bus.ex_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_issue(4'(8 + i), 16'(256 + i), 16'(512 + i), 3'd0, 3'd0);
            chk("t4_iss_tag", 64'(bus.iss_tag), 64'(i + 1));
            tick();
        end
        set_issue(4'd15, 16'hDEAD, 16'hBEEF, 3'd0, 3'd0);
        chk("t4_full_count", 64'(bus.count), 64'd4);
        chk("t4_full_ready", 64'(bus.iss_ready), 64'd0);
        tick();
        bus.iss_valid = 1'b0;
        chk("t4_fifth_ignored", 64'(bus.count), 64'd4);
        bus.ex_ready = 1'b1;
        exp_q.push_back(rec(4'd8, 16'd256, 16'd512, 3'd1));
        tick();
        bus.ex_ready = 1'b0;
        chk("t4_iss_ready", 64'(bus.iss_ready), 64'd1);
        chk("t4_iss_tag_freed", 64'(bus.iss_tag), 64'd1);
        chk("t4_count", 64'(bus.count), 64'd3);
        chk("t4_next_ex_tag", 64'(bus.ex_tag), 64'd2);

        // Asynchronous reset in the middle of a stall
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ex_valid", 64'(bus.ex_valid), 64'd0);
        chk("arst_count", 64'(bus.count), 64'd0);
        chk("arst_iss_ready", 64'(bus.iss_ready), 64'd1);
        #2;
        rst_n = 1'b1;
        tick();

        // Flush outranks a same-cycle issue and releases the lock
        for (int i = 0; i < 3; i++) begin
            set_issue(4'(1 + i), 16'(16 + i), 16'(32 + i), 3'd0, 3'd0);
            tick();
        end
        bus.iss_valid = 1'b0;
        chk("fl_pre_count", 64'(bus.count), 64'd3);
        chk("fl_pre_ex_valid", 64'(bus.ex_valid), 64'd1);
        flush = 1'b1;
        set_issue(4'd7, 16'd1, 16'd1, 3'd0, 3'd0);
        tick();
        flush = 1'b0;
        bus.iss_valid = 1'b0;
        chk("fl_count", 64'(bus.count), 64'd0);
        chk("fl_ex_valid", 64'(bus.ex_valid), 64'd0);
        chk("fl_ex_tag", 64'(bus.ex_tag), 64'd0);
        chk("fl_iss_tag", 64'(bus.iss_tag), 64'd1);

        // Stalled selection of entry 1 survives entry 0 becoming ready
        set_issue(4'd1, 16'd0, 16'h0033, 3'd5, 3'd0);
        tick();
        set_issue(4'd2, 16'h0044, 16'h0055, 3'd0, 3'd0);
        tick();
        bus.iss_valid = 1'b0;
        chk("lk_ex_tag_first", 64'(bus.ex_tag), 64'd2);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 3'd5;
        bus.cdb_value = 16'h0066;
        tick();
        bus.cdb_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("lk_ex_tag_held", 64'(bus.ex_tag), 64'd2);
            tick();
        end
        exp_q.push_back(rec(4'd2, 16'h0044, 16'h0055, 3'd2));
        exp_q.push_back(rec(4'd1, 16'h0066, 16'h0033, 3'd1));
        bus.ex_ready = 1'b1;
        tick();
        chk("lk_ex_tag_next", 64'(bus.ex_tag), 64'd1);
        chk("lk_ex_valid_next", 64'(bus.ex_valid), 64'd1);
        tick();
        bus.ex_ready = 1'b0;
        chk("lk_count", 64'(bus.count), 64'd0);

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
